// File: rtl/pad_owner_pkg.sv
// pad_owner_pkg
//  Shared definitions for the pad ring ownership controller:
//  FSM state encoding, PARK id helper, default timing constants and a
//  small max helper for sizing the shared phase counter.
package pad_owner_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACTIVE  = 3'd1,
        QUIESCE = 3'd2,
        GAP     = 3'd3,
        WAKE    = 3'd4
    } state_t;

    localparam int DEF_NUM_IP     = 4;
    localparam int DEF_PAD_W      = 82;
    localparam int DEF_GAP_CYCLES = 4;
    localparam int DEF_RST_CYCLES = 8;
    localparam int DEF_QTO_CYCLES = 256;

    // Any id >= NUM_IP means "no owner"; this is the canonical PARK value.
    function automatic int park_id(input int num_ip);
        return num_ip;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pad_owner_mux.sv
// pad_owner_mux
//  Registered one-hot pad mux. When gate is high the selected IP's
//  pad_o/pad_oe slice is driven to the pad ring one cycle later; when gate
//  is low the ring is driven with zeros (all pads tri-stated).
//  Ports:
//   clk, rst        clock, async active-high reset
//   gate            owner is allowed to drive the pads
//   sel             one-hot owner select (all-zero selects nothing)
//   ip_pad_o/_oe    packed IP pad buses, IP i at [i*PAD_W +: PAD_W]
//   pad_o/_oe       registered pad ring outputs
module pad_owner_mux
    import pad_owner_pkg::*;
#(
    parameter int NUM_IP = DEF_NUM_IP,
    parameter int PAD_W  = DEF_PAD_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    gate,
    input  logic [NUM_IP-1:0]       sel,
    input  logic [NUM_IP*PAD_W-1:0] ip_pad_o,
    input  logic [NUM_IP*PAD_W-1:0] ip_pad_oe,
    output logic [PAD_W-1:0]        pad_o,
    output logic [PAD_W-1:0]        pad_oe
);

    logic [PAD_W-1:0] pad_o_d, pad_oe_d;
    logic [PAD_W-1:0] pad_o_q, pad_oe_q;

    // AND-OR mux: a one-hot select never ORs two IPs together.
    always_comb begin
        pad_o_d  = '0;
        pad_oe_d = '0;
        for (int i = 0; i < NUM_IP; i++) begin
            pad_o_d  = pad_o_d  | (ip_pad_o[i*PAD_W +: PAD_W]  & {PAD_W{sel[i]}});
            pad_oe_d = pad_oe_d | (ip_pad_oe[i*PAD_W +: PAD_W] & {PAD_W{sel[i]}});
        end
        if (!gate) begin
            pad_o_d  = '0;
            pad_oe_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_o_q  <= '0;
            pad_oe_q <= '0;
        end else begin
            pad_o_q  <= pad_o_d;
            pad_oe_q <= pad_oe_d;
        end
    end

    assign pad_o  = pad_o_q;
    assign pad_oe = pad_oe_q;

endmodule

// File: rtl/pad_owner_ctrl.sv
// pad_owner_ctrl
//  Arbitrates ownership of the shared chip pad ring between NUM_IP cores.
//  An ownership change runs QUIESCE (old owner reaches a safe point, with
//  timeout) -> GAP (all pads off, everyone in reset) -> WAKE (new owner out
//  of reset, pads still off) -> ACTIVE (new owner drives the pads).
//  Ports:
//   clk, rst              clock, async active-high reset
//   sel_req_valid/_id     ownership request, id >= NUM_IP parks the ring
//   sel_req_ready         request accepted on valid && ready
//   quiesce_req/_ack      one-hot safe-point handshake with the owner
//   ip_rst                per-IP reset, only the owner (or waking IP) is released
//   ip_pad_o/_oe          packed IP pad buses
//   pad_o/_oe             pad ring outputs (registered)
//   owner_valid/owner_id  current owner status
//   busy                  switch in progress
//   timeout_o             sticky quiesce timeout, cleared on next accepted request
module pad_owner_ctrl
    import pad_owner_pkg::*;
#(
    parameter int NUM_IP     = DEF_NUM_IP,
    parameter int PAD_W      = DEF_PAD_W,
    parameter int IDW        = $clog2(NUM_IP + 1),
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int QTO_CYCLES = DEF_QTO_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel_req_valid,
    input  logic [IDW-1:0]          sel_req_id,
    output logic                    sel_req_ready,
    output logic [NUM_IP-1:0]       quiesce_req,
    input  logic [NUM_IP-1:0]       quiesce_ack,
    output logic [NUM_IP-1:0]       ip_rst,
    input  logic [NUM_IP*PAD_W-1:0] ip_pad_o,
    input  logic [NUM_IP*PAD_W-1:0] ip_pad_oe,
    output logic [PAD_W-1:0]        pad_o,
    output logic [PAD_W-1:0]        pad_oe,
    output logic                    owner_valid,
    output logic [IDW-1:0]          owner_id,
    output logic                    busy,
    output logic                    timeout_o
);

    localparam int CNT_MAX = max3(GAP_CYCLES, RST_CYCLES, QTO_CYCLES);
    localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
    localparam logic [IDW-1:0] PARK = IDW'(park_id(NUM_IP));

    function automatic logic [NUM_IP-1:0] id_oh(input logic [IDW-1:0] id);
        logic [NUM_IP-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_IP; i++)
            if (id == IDW'(i)) oh[i] = 1'b1;
        return oh;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0]    owner_id_q, owner_id_d;
    logic [IDW-1:0]    new_id_q, new_id_d;
    logic              timeout_q, timeout_d;
    logic              owner_valid_q, owner_valid_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic [NUM_IP-1:0] quiesce_req_q, quiesce_req_d;
    logic [NUM_IP-1:0] ip_rst_q, ip_rst_d;

    logic              req_acc;
    logic              owner_ack;

    assign req_acc   = sel_req_valid && ready_q;
    // Only the current owner's ack counts; other bits are ignored.
    assign owner_ack = |(quiesce_ack & id_oh(owner_id_q));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        owner_id_d = owner_id_q;
        new_id_d   = new_id_q;
        timeout_d  = timeout_q;

        if (req_acc) timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Nobody to quiesce, go straight to the tri-state gap.
                if (req_acc && sel_req_id < PARK) begin
                    new_id_d = sel_req_id;
                    state_d  = GAP;
                end
            end
            ACTIVE: begin
                if (req_acc && sel_req_id != owner_id_q) begin
                    new_id_d = sel_req_id;
                    state_d  = QUIESCE;
                end
            end
            QUIESCE: begin
                // Ack wins over a coincident timeout.
                if (owner_ack) begin
                    state_d = GAP;
                end else if (cnt_q == CNT_W'(QTO_CYCLES - 1)) begin
                    state_d   = GAP;
                    timeout_d = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    if (new_id_q >= PARK) begin
                        state_d    = IDLE;
                        owner_id_d = '0;
                    end else begin
                        state_d = WAKE;
                    end
                end
            end
            WAKE: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d    = ACTIVE;
                    owner_id_d = new_id_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared counter restarts on every state entry and idles at zero.
        if (state_d != state_q || state_d == IDLE || state_d == ACTIVE)
            cnt_d = '0;

        // Outputs are decoded from the next state so they come out registered.
        owner_valid_d = (state_d == ACTIVE) || (state_d == QUIESCE);
        busy_d        = (state_d == QUIESCE) || (state_d == GAP) || (state_d == WAKE);
        ready_d       = !busy_d;
        quiesce_req_d = (state_d == QUIESCE) ? id_oh(owner_id_d) : '0;
        case (state_d)
            ACTIVE, QUIESCE: ip_rst_d = ~id_oh(owner_id_d);
            WAKE:            ip_rst_d = ~id_oh(new_id_d);
            default:         ip_rst_d = '1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            owner_id_q    <= '0;
            new_id_q      <= '0;
            timeout_q     <= 1'b0;
            owner_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b1;
            quiesce_req_q <= '0;
            ip_rst_q      <= '1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_id_q    <= owner_id_d;
            new_id_q      <= new_id_d;
            timeout_q     <= timeout_d;
            owner_valid_q <= owner_valid_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            quiesce_req_q <= quiesce_req_d;
            ip_rst_q      <= ip_rst_d;
        end
    end

    // Gate with the registered owner_valid so pad_oe trails it by one cycle.
    pad_owner_mux #(
        .NUM_IP (NUM_IP),
        .PAD_W  (PAD_W)
    ) u_mux (
        .clk       (clk),
        .rst       (rst),
        .gate      (owner_valid_q),
        .sel       (id_oh(owner_id_q)),
        .ip_pad_o  (ip_pad_o),
        .ip_pad_oe (ip_pad_oe),
        .pad_o     (pad_o),
        .pad_oe    (pad_oe)
    );

    assign sel_req_ready = ready_q;
    assign quiesce_req   = quiesce_req_q;
    assign ip_rst        = ip_rst_q;
    assign owner_valid   = owner_valid_q;
    assign owner_id      = owner_id_q;
    assign busy          = busy_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_pad_owner_ctrl.sv
// tb_pad_owner_ctrl
//  Self-checking bench for pad_owner_ctrl. A transaction-level model turns
//  each accepted request into a queue of expected per-cycle snapshots
//  (quiesce, gap, wake, settle) and the DUT is compared every cycle.
module tb_pad_owner_ctrl;

    localparam int NUM_IP = 4;
    localparam int PAD_W  = 82;
    localparam int IDW    = 3;
    localparam int GAPC   = 4;
    localparam int RSTC   = 8;
    localparam int QTO    = 256;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    sel_req_valid;
    logic [IDW-1:0]          sel_req_id;
    logic                    sel_req_ready;
    logic [NUM_IP-1:0]       quiesce_req;
    logic [NUM_IP-1:0]       quiesce_ack;
    logic [NUM_IP-1:0]       ip_rst;
    logic [NUM_IP*PAD_W-1:0] ip_pad_o;
    logic [NUM_IP*PAD_W-1:0] ip_pad_oe;
    logic [PAD_W-1:0]        pad_o;
    logic [PAD_W-1:0]        pad_oe;
    logic                    owner_valid;
    logic [IDW-1:0]          owner_id;
    logic                    busy;
    logic                    timeout_o;

    always #5 clk = ~clk;

    pad_owner_ctrl #(
        .NUM_IP(NUM_IP), .PAD_W(PAD_W), .IDW(IDW),
        .GAP_CYCLES(GAPC), .RST_CYCLES(RSTC), .QTO_CYCLES(QTO)
    ) dut (
        .clk(clk), .rst(rst),
        .sel_req_valid(sel_req_valid), .sel_req_id(sel_req_id),
        .sel_req_ready(sel_req_ready),
        .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack),
        .ip_rst(ip_rst),
        .ip_pad_o(ip_pad_o), .ip_pad_oe(ip_pad_oe),
        .pad_o(pad_o), .pad_oe(pad_oe),
        .owner_valid(owner_valid), .owner_id(owner_id),
        .busy(busy), .timeout_o(timeout_o)
    );

    typedef struct {
        logic              busy;
        logic              ov;
        logic [IDW-1:0]    oid;
        logic [NUM_IP-1:0] rstv;
        logic [NUM_IP-1:0] qreq;
        logic              tmo;
        int                qk;    // quiesce cycle index, -1 outside quiesce
    } snap_t;

    snap_t cur, prv;
    snap_t plan[$];
    int    ack_d;
    int    force_ack = -1;
    int    checks = 0;
    int    errors = 0;
    logic  last_acc;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [NUM_IP-1:0] oh(input int id);
        logic [NUM_IP-1:0] r;
        r = '0;
        if (id >= 0 && id < NUM_IP) r[id] = 1'b1;
        return r;
    endfunction

    function automatic snap_t mk(input logic b, input logic ov, input int oid,
                                 input logic [NUM_IP-1:0] rv, input logic [NUM_IP-1:0] qr,
                                 input logic tmo, input int qk);
        snap_t s;
        s.busy = b; s.ov = ov; s.oid = IDW'(oid); s.rstv = rv;
        s.qreq = qr; s.tmo = tmo; s.qk = qk;
        return s;
    endfunction

    task automatic model_reset();
        cur = mk(1'b0, 1'b0, 0, '1, '0, 1'b0, -1);
        prv = cur;
        plan.delete();
    endtask

    // Expand one accepted ownership change into its expected cycle timeline.
    task automatic plan_switch(input int id);
        int   old;
        int   len;
        logic to;
        old   = int'(cur.oid);
        ack_d = (force_ack >= 0) ? force_ack
              : (($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 6)));
        to = 1'b0;
        if (cur.ov) begin
            len = (ack_d < QTO) ? ack_d + 1 : QTO;
            to  = (ack_d >= QTO);
            for (int k = 0; k < len; k++)
                plan.push_back(mk(1'b1, 1'b1, old, ~oh(old), oh(old), 1'b0, k));
        end
        for (int k = 0; k < GAPC; k++)
            plan.push_back(mk(1'b1, 1'b0, old, '1, '0, to, -1));
        if (id >= NUM_IP) begin
            plan.push_back(mk(1'b0, 1'b0, 0, '1, '0, to, -1));
        end else begin
            for (int k = 0; k < RSTC; k++)
                plan.push_back(mk(1'b1, 1'b0, old, ~oh(id), '0, to, -1));
            plan.push_back(mk(1'b0, 1'b1, id, ~oh(id), '0, to, -1));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_iprst"}, 128'(ip_rst), 128'(4'hF));
        chk({tag, "_padoe"}, 128'(pad_oe), 128'(0));
        chk({tag, "_pado"},  128'(pad_o), 128'(0));
        chk({tag, "_ready"}, 128'(sel_req_ready), 128'(1));
        chk({tag, "_busy"},  128'(busy), 128'(0));
        chk({tag, "_ov"},    128'(owner_valid), 128'(0));
        chk({tag, "_oid"},   128'(owner_id), 128'(0));
        chk({tag, "_qreq"},  128'(quiesce_req), 128'(0));
        chk({tag, "_tmo"},   128'(timeout_o), 128'(0));
    endtask

    // Called at a negedge: drive inputs, clock once, update model, compare.
    task automatic step(input logic v, input int id);
        logic [NUM_IP-1:0] a;
        logic [PAD_W-1:0]  eo, eoe;
        logic              acc;
        sel_req_valid = v;
        sel_req_id    = IDW'(id);
        for (int b = 0; b < NUM_IP*PAD_W; b++) begin
            ip_pad_o[b]  = 1'($urandom);
            ip_pad_oe[b] = 1'($urandom);
        end
        a = NUM_IP'($urandom);
        if (cur.qk >= 0) a[int'(cur.oid)] = (cur.qk >= ack_d);
        quiesce_ack = a;
        acc = v && !cur.busy;
        last_acc = acc;
        @(posedge clk);
        prv = cur;
        if (acc) begin
            if ((!cur.ov && id >= NUM_IP) || (cur.ov && id == int'(cur.oid)))
                cur.tmo = 1'b0;
            else
                plan_switch(id);
        end
        if (plan.size() > 0) cur = plan.pop_front();
        eo  = prv.ov ? ip_pad_o[int'(prv.oid)*PAD_W +: PAD_W]  : '0;
        eoe = prv.ov ? ip_pad_oe[int'(prv.oid)*PAD_W +: PAD_W] : '0;
        #1;
        chk("busy",    128'(busy), 128'(cur.busy));
        chk("ready",   128'(sel_req_ready), 128'(!cur.busy));
        chk("ov",      128'(owner_valid), 128'(cur.ov));
        chk("oid",     128'(owner_id), 128'(cur.oid));
        chk("ip_rst",  128'(ip_rst), 128'(cur.rstv));
        chk("qreq",    128'(quiesce_req), 128'(cur.qreq));
        chk("timeout", 128'(timeout_o), 128'(cur.tmo));
        chk("pad_o",   128'(pad_o), 128'(eo));
        chk("pad_oe",  128'(pad_oe), 128'(eoe));
        chk("onehot0", 128'($onehot0(~ip_rst)), 128'(1));
        @(negedge clk);
    endtask

    // Async reset between clock edges, checked before the next edge.
    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1 chk_reset(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic hv;
        int   hid;
        sel_req_valid = 1'b0;
        sel_req_id    = '0;
        quiesce_ack   = '0;
        ip_pad_o      = '0;
        ip_pad_oe     = '1;
        last_acc      = 1'b0;
        model_reset();

        // Reset with every IP requesting all pads enabled.
        #2 rst = 1'b1;
        #1 chk_reset("rst_async");
        repeat (3) @(posedge clk);
        #1 chk_reset("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 0);

        // Claim from IDLE.
        step(1'b1, 2);
        repeat (14) step(1'b0, 0);

        // Switch 2->1 with ack three cycles into quiesce.
        force_ack = 3;
        step(1'b1, 1);
        repeat (20) step(1'b0, 0);

        // Switch with no ack: timeout, then same-id request clears it.
        force_ack = 1000;
        step(1'b1, 3);
        repeat (270) step(1'b0, 0);
        step(1'b1, 3);
        step(1'b0, 0);

        // Park from ACTIVE, then requests held while busy.
        force_ack = 0;
        step(1'b1, 7);
        repeat (15) step(1'b0, 0);
        step(1'b1, 0);
        repeat (40) step(1'b1, 2);
        step(1'b0, 0);

        // Reset mid-GAP and mid-WAKE, then a fresh claim.
        step(1'b1, 4);
        repeat (12) step(1'b0, 0);
        step(1'b1, 1);
        repeat (2) step(1'b0, 0);
        mid_reset("rst_gap");
        step(1'b1, 1);
        repeat (7) step(1'b0, 0);
        mid_reset("rst_wake");
        step(1'b1, 0);
        repeat (14) step(1'b0, 0);

        // Random traffic with requests held until accepted.
        force_ack = -1;
        hv  = 1'b0;
        hid = 0;
        repeat (3000) begin
            if (!hv && $urandom_range(0, 3) == 0) begin
                hv  = 1'b1;
                hid = int'($urandom_range(0, 7));
            end
            step(hv, hid);
            if (last_acc) hv = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
